// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the program/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ADDR,
    CPU_DATA,
    LD_ADDR,
    LD_DATA
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_LD
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU port, loader port and memory-side signals of the arbiter.
// slave: the arbiter's view; master: the surrounding CPU/loader/memory.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          ld_req;
  logic          ld_wr;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ld_req, ld_wr, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ld_req, ld_wr, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port program/data memory. The CPU has
// fixed priority; a loader that has waited MAX_WAIT cycles beats the CPU.
// Every access is a two-cycle ADDR/DATA transaction.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned   WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  arb_state_t    state_q, state_d;
  owner_t        owner_q;
  logic [WW-1:0] wait_cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          wr_q;
  logic          cpu_rvalid_q;
  logic          ld_rvalid_q;
  logic          in_addr;
  logic          in_data;
  logic          ld_owns;

  assign in_addr = (state_q == CPU_ADDR) || (state_q == LD_ADDR);
  assign in_data = (state_q == CPU_DATA) || (state_q == LD_DATA);
  assign ld_owns = (state_q == LD_ADDR)  || (state_q == LD_DATA);

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: arbitrate whenever the bus is idle or finishing a DATA cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, CPU_DATA, LD_DATA: begin
        if (bus.ld_req && (!bus.cpu_req || wait_cnt == WAIT_MAX)) state_d = LD_ADDR;
        else if (bus.cpu_req)                                     state_d = CPU_ADDR;
        else                                                      state_d = IDLE;
      end
      CPU_ADDR: state_d = CPU_DATA;
      LD_ADDR:  state_d = LD_DATA;
      default:  state_d = IDLE;
    endcase
  end

  // Latch the winner's access on entry to an ADDR state; capture read data in DATA.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      owner_q      <= OWN_CPU;
      rdata_q      <= '0;
      cpu_rvalid_q <= 1'b0;
      ld_rvalid_q  <= 1'b0;
    end else begin
      if (state_d == CPU_ADDR) begin
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
        wr_q    <= bus.cpu_wr;
        owner_q <= OWN_CPU;
      end else if (state_d == LD_ADDR) begin
        addr_q  <= bus.ld_addr;
        wdata_q <= bus.ld_wdata;
        wr_q    <= bus.ld_wr;
        owner_q <= OWN_LD;
      end
      if (in_data && !wr_q) rdata_q <= bus.mem_rdata;
      cpu_rvalid_q <= in_data && !wr_q && (owner_q == OWN_CPU);
      ld_rvalid_q  <= in_data && !wr_q && (owner_q == OWN_LD);
    end
  end

  // Starvation counter: counts loader-requesting cycles while the loader is not served.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                                                wait_cnt <= '0;
    else if (state_d == LD_ADDR)                              wait_cnt <= '0;
    else if (bus.ld_req && !ld_owns && wait_cnt != WAIT_MAX)  wait_cnt <= wait_cnt + 1'b1;
  end

  assign bus.cpu_gnt    = in_addr && (owner_q == OWN_CPU);
  assign bus.ld_gnt     = in_addr && (owner_q == OWN_LD);
  assign bus.mem_rd     = in_addr && !wr_q;
  assign bus.mem_wr     = in_addr && wr_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.ld_rvalid  = ld_rvalid_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.ld_rdata   = rdata_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level reference
// predicts grants and read results; a monitor pops and compares them.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 8;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned DEPTH    = 2 ** AW;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    int            cyc;
    bit            ld;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  op_t  cpu_ops[$];
  op_t  ld_ops[$];
  exp_t gnt_q[$];
  exp_t rv_q[$];
  bit   agents_en   = 0;
  bit   rand_en     = 0;
  int   p_cpu       = 0;
  int   p_ld        = 0;
  int   m_left      = 0;
  int   m_wait      = 0;
  bit   m_owner_ld  = 0;
  bit   m_busy      = 0;

  function automatic logic [DW-1:0] init_val(int unsigned i);
    if (i == 32'h0A) return 8'h3C;
    return DW'(i * 37 + 11);
  endfunction

  // Memory responder: data appears in the cycle after mem_rd; garbage otherwise.
  initial begin : responder
    logic [DW-1:0] phys_mem [DEPTH];
    for (int unsigned i = 0; i < DEPTH; i++) phys_mem[i] = init_val(i);
    bus.mem_rdata <= '0;
    forever begin
      @(posedge clk);
      if (bus.mem_wr) phys_mem[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata <= bus.mem_rd ? phys_mem[bus.mem_addr] : DW'($urandom);
    end
  end

  // Reference model: the bus frees up every two cycles after a win; the
  // loader wins when alone or after MAX_WAIT unserved requesting cycles.
  initial begin : model
    logic [DW-1:0] ref_mem [DEPTH];
    bit   decide, in_ld, win_ld, win_cpu;
    exp_t e;
    for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk or negedge rst_);
      if (!rst_) begin
        m_left = 0; m_wait = 0; m_busy = 0;
        gnt_q.delete(); rv_q.delete();
      end else begin
        cyc     = cyc + 1;
        in_ld   = (m_left > 0) && m_owner_ld;
        decide  = (m_left <= 1);
        win_ld  = decide && bus.ld_req && (!bus.cpu_req || m_wait >= int'(MAX_WAIT));
        win_cpu = decide && !win_ld && bus.cpu_req;
        if (win_ld) m_wait = 0;
        else if (bus.ld_req && !in_ld && m_wait < int'(MAX_WAIT)) m_wait = m_wait + 1;
        if (win_ld || win_cpu) begin
          e.cyc  = cyc;
          e.ld   = win_ld;
          e.wr   = win_ld ? bus.ld_wr    : bus.cpu_wr;
          e.addr = win_ld ? bus.ld_addr  : bus.cpu_addr;
          e.data = win_ld ? bus.ld_wdata : bus.cpu_wdata;
          gnt_q.push_back(e);
          if (e.wr) ref_mem[e.addr] = e.data;
          else begin
            e.cyc  = cyc + 2;
            e.data = ref_mem[e.addr];
            rv_q.push_back(e);
          end
          m_left     = 2;
          m_owner_ld = win_ld;
        end else if (decide) m_left = 0;
        else m_left = m_left - 1;
        m_busy = (m_left > 0);
      end
    end
  end

  task automatic check_cycle();
    exp_t e;
    logic [DW-1:0] rd;
    while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
      e = gnt_q.pop_front();
      vectors++; miscompares++;
      $display("FAIL gnt_missing: no grant seen, want ld=%0b addr=%h at cycle %0d", e.ld, e.addr, e.cyc);
    end
    while (rv_q.size() > 0 && rv_q[0].cyc < cyc) begin
      e = rv_q.pop_front();
      vectors++; miscompares++;
      $display("FAIL rvalid_missing: no rvalid seen, want ld=%0b data=%h at cycle %0d", e.ld, e.data, e.cyc);
    end
    if (bus.cpu_gnt || bus.ld_gnt || bus.mem_rd || bus.mem_wr) begin
      vectors++;
      if (gnt_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_access @%0d: got cpu_gnt=%b ld_gnt=%b rd=%b wr=%b addr=%h, want no access",
                 cyc, bus.cpu_gnt, bus.ld_gnt, bus.mem_rd, bus.mem_wr, bus.mem_addr);
      end else begin
        e = gnt_q.pop_front();
        if (e.cyc != cyc || bus.ld_gnt != e.ld || bus.cpu_gnt != !e.ld || bus.mem_wr != e.wr ||
            bus.mem_rd != !e.wr || bus.mem_addr != e.addr || (e.wr && bus.mem_wdata != e.data)) begin
          miscompares++;
          $display("FAIL grant @%0d: got cpu_gnt=%b ld_gnt=%b rd=%b wr=%b addr=%h wdata=%h, want ld=%0b wr=%0b addr=%h wdata=%h @%0d",
                   cyc, bus.cpu_gnt, bus.ld_gnt, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
                   e.ld, e.wr, e.addr, e.data, e.cyc);
        end
      end
    end
    if (bus.cpu_rvalid || bus.ld_rvalid) begin
      vectors++;
      if (rv_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rvalid @%0d: got cpu_rvalid=%b ld_rvalid=%b, want none",
                 cyc, bus.cpu_rvalid, bus.ld_rvalid);
      end else begin
        e  = rv_q.pop_front();
        rd = e.ld ? bus.ld_rdata : bus.cpu_rdata;
        if (e.cyc != cyc || bus.ld_rvalid != e.ld || bus.cpu_rvalid != !e.ld || rd != e.data) begin
          miscompares++;
          $display("FAIL rvalid @%0d: got cpu_rvalid=%b ld_rvalid=%b rdata=%h, want ld=%0b rdata=%h @%0d",
                   cyc, bus.cpu_rvalid, bus.ld_rvalid, rd, e.ld, e.data, e.cyc);
        end
      end
    end
    vectors++;
    if (bus.busy != m_busy) begin
      miscompares++;
      $display("FAIL busy @%0d: got %b, want %b", cyc, bus.busy, m_busy);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_) check_cycle();
    end
  end

  // Requester agents: hold each request until granted, then take the next op.
  initial begin : agents
    op_t o;
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_req  = 0; bus.ld_wr  = 0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
    forever begin
      @(negedge clk);
      if (!agents_en) begin
        bus.cpu_req = 0;
        bus.ld_req  = 0;
      end else begin
        if (bus.cpu_req && bus.cpu_gnt) bus.cpu_req = 0;
        if (bus.ld_req && bus.ld_gnt)   bus.ld_req  = 0;
        if (!bus.cpu_req) begin
          if (cpu_ops.size() > 0) begin
            o = cpu_ops.pop_front();
            bus.cpu_req = 1; bus.cpu_wr = o.wr; bus.cpu_addr = o.addr; bus.cpu_wdata = o.data;
          end else if (rand_en && $urandom_range(99) < p_cpu) begin
            bus.cpu_req = 1; bus.cpu_wr = 1'($urandom_range(1));
            bus.cpu_addr = AW'($urandom); bus.cpu_wdata = DW'($urandom);
          end
        end
        if (!bus.ld_req) begin
          if (ld_ops.size() > 0) begin
            o = ld_ops.pop_front();
            bus.ld_req = 1; bus.ld_wr = o.wr; bus.ld_addr = o.addr; bus.ld_wdata = o.data;
          end else if (rand_en && $urandom_range(99) < p_ld) begin
            bus.ld_req = 1; bus.ld_wr = 1'($urandom_range(1));
            bus.ld_addr = AW'($urandom); bus.ld_wdata = DW'($urandom);
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    logic [4*DW+AW+6:0] got;
    got = {bus.cpu_gnt, bus.ld_gnt, bus.cpu_rvalid, bus.ld_rvalid, bus.mem_rd, bus.mem_wr,
           bus.busy, bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.ld_rdata, bus.ld_rdata};
    vectors++;
    if (got != '0) begin
      miscompares++;
      $display("FAIL %s: outputs got %h, want all zero", name, got);
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk); #1;
      done = cpu_ops.size() == 0 && ld_ops.size() == 0 && !bus.cpu_req && !bus.ld_req &&
             gnt_q.size() == 0 && rv_q.size() == 0 && !m_busy;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d grants / %0d reads outstanding, want 0", gnt_q.size(), rv_q.size());
    end
  endtask

  initial begin : main
    bit found;
    repeat (2) @(negedge clk);
    #1 check_zero("reset_values");
    #1 rst_ = 1;
    agents_en = 1;

    cpu_ops.push_back('{wr: 0, addr: 5'h0A, data: 8'h00});
    drain();
    ld_ops.push_back('{wr: 1, addr: 5'h1F, data: 8'hA5});
    drain();
    cpu_ops.push_back('{wr: 0, addr: 5'h01, data: 8'h00});
    ld_ops.push_back('{wr: 0, addr: 5'h02, data: 8'h00});
    drain();
    cpu_ops.push_back('{wr: 0, addr: 5'h01, data: 8'h00});
    cpu_ops.push_back('{wr: 0, addr: 5'h02, data: 8'h00});
    drain();
    for (int i = 0; i < 6; i++) cpu_ops.push_back('{wr: 0, addr: AW'(i + 3), data: 8'h00});
    ld_ops.push_back('{wr: 1, addr: 5'h04, data: 8'h5A});
    drain();

    rand_en = 1;
    p_cpu = 50;  p_ld = 30;  repeat (2000) @(negedge clk);
    p_cpu = 100; p_ld = 100; repeat (600)  @(negedge clk);
    p_cpu = 20;  p_ld = 60;  repeat (1000) @(negedge clk);
    rand_en = 0;
    drain();

    cpu_ops.push_back('{wr: 0, addr: 5'h0A, data: 8'h00});
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      found = bus.cpu_gnt;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reset_setup: got no cpu_gnt within 20 cycles, want one");
    end
    #1 rst_ = 0;
    #1 check_zero("reset_mid_txn");
    repeat (3) @(negedge clk);
    #2 rst_ = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      vectors++;
      if ({bus.cpu_rvalid, bus.ld_rvalid, bus.cpu_gnt, bus.busy} != 4'b0000) begin
        miscompares++;
        $display("FAIL post_reset: got rvalid=%b gnt=%b busy=%b, want 0",
                 bus.cpu_rvalid, bus.cpu_gnt, bus.busy);
      end
    end

    rand_en = 1;
    p_cpu = 60; p_ld = 40; repeat (500) @(negedge clk);
    rand_en = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
